spi_slave_core: RTL and testbench

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_core.sv | 165 ++++++++++++++++
 tb/tb_spi_slave_core.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave core: mode bundle, FSM states,
// and bit-order aware shift helpers.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic msb_first;
  } spi_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  function automatic logic head_bit(input logic [BYTE_W-1:0] sr, input logic msb);
    return msb ? sr[BYTE_W-1] : sr[0];
  endfunction

  function automatic logic [BYTE_W-1:0] shift_out(input logic [BYTE_W-1:0] sr, input logic msb);
    return msb ? {sr[BYTE_W-2:0], 1'b0} : {1'b0, sr[BYTE_W-1:1]};
  endfunction

  function automatic logic [BYTE_W-1:0] shift_in(input logic [BYTE_W-1:0] sr, input logic b,
                                                 input logic msb);
    return msb ? {sr[BYTE_W-2:0], b} : {b, sr[BYTE_W-1:1]};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus rise/fall detection
// against one extra history flop.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave core, all four modes, either bit order, oversampled on clk.
// Define SPI_SLAVE_STATUS_EN to build the sticky overrun/underrun flags.
//
// state | meaning
// IDLE  | cs_n high, miso held 0
// LOAD  | one cycle after cs_n fall: fetch first TX byte
// SHIFT | frame active, bits move on spi_clk edges
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              msb_first,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overrun,
  output logic              underrun,
  input  logic              clr_status
);

  spi_mode_t         mode;
  spi_state_t        state, state_nxt;
  logic              sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic              mosi_s;
  logic              lead, trail, sample_edge, drive_edge;
  logic              fetch, byte_done, ovr_set, udr_set;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] rx_sr, rx_nxt, tx_sr, load_val;
  logic              miso_q;

  assign mode = '{cpol: cpol, cpha: cpha, msb_first: msb_first};

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .nrst(nrst), .d(spi_clk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .nrst(nrst), .d(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi uses the same depth so it lines up with the detected spi_clk edge
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead        = mode.cpol ? sclk_fall : sclk_rise;
  assign trail       = mode.cpol ? sclk_rise : sclk_fall;
  assign sample_edge = mode.cpha ? trail : lead;
  assign drive_edge  = mode.cpha ? lead  : trail;

  assign byte_done = (state == SHIFT) && sample_edge && (bit_cnt == 3'd7) && !cs_rise;
  assign rx_nxt    = shift_in(rx_sr, mosi_s, mode.msb_first);

  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    case (state)
      IDLE:    if (cs_fall) state_nxt = LOAD;
      LOAD:    begin
                 fetch     = 1'b1;
                 state_nxt = SHIFT;
               end
      SHIFT:   fetch = byte_done;
      default: state_nxt = IDLE;
    endcase
    if (cs_rise) begin
      state_nxt = IDLE;
      fetch     = 1'b0;
    end
  end

  assign tx_ready = fetch & tx_valid;
  assign udr_set  = fetch & ~tx_valid;
  assign load_val = tx_valid ? tx_data : '0;
  assign ovr_set  = byte_done && rx_valid && !rx_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
      miso_q  <= 1'b0;
    end else if (state_nxt == IDLE) begin
      bit_cnt <= '0;
      miso_q  <= 1'b0;
    end else begin
      if (state == SHIFT && sample_edge) begin
        rx_sr   <= rx_nxt;
        bit_cnt <= bit_cnt + 3'd1;
      end
      // cpha=0 must present the first bit before any clock edge arrives
      if (fetch && state == LOAD && !mode.cpha) begin
        miso_q <= head_bit(load_val, mode.msb_first);
        tx_sr  <= shift_out(load_val, mode.msb_first);
      end else if (fetch) begin
        tx_sr <= load_val;
      end else if (state == SHIFT && drive_edge) begin
        miso_q <= head_bit(tx_sr, mode.msb_first);
        tx_sr  <= shift_out(tx_sr, mode.msb_first);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (byte_done && (!rx_valid || rx_ready)) begin
      rx_data  <= rx_nxt;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign spi_miso = miso_q;
  assign busy     = (state != IDLE);

`ifdef SPI_SLAVE_STATUS_EN
  logic ovr_q, udr_q;

  // a new error in the same cycle as clr_status keeps the flag set
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (ovr_set)         ovr_q <= 1'b1;
      else if (clr_status) ovr_q <= 1'b0;
      if (udr_set)         udr_q <= 1'b1;
      else if (clr_status) udr_q <= 1'b0;
    end
  end

  assign overrun  = ovr_q;
  assign underrun = udr_q;
`else
  logic unused_status;
  assign unused_status = ^{clr_status, ovr_set, udr_set};
  assign overrun       = 1'b0;
  assign underrun      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: bit-banged SPI master, TX byte
// source, and an RX scoreboard fed from the stimulus.
module tb_spi_slave_core;

  localparam int HALF = 8;
`ifdef SPI_SLAVE_STATUS_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic spi_miso;
  logic cpol = 1'b0, cpha = 1'b0, msb_first = 1'b1;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready = 1'b1;
  logic busy, overrun, underrun;
  logic clr_status = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       msb;
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun), .clr_status(clr_status)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // TX byte source: pops a byte after each tx_ready strobe
  initial begin
    logic fetched;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      fetched = tx_ready;
      @(posedge clk);
      #1;
      if (fetched && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_valid = (tx_q.size() > 0);
      tx_data  = tx_valid ? tx_q[0] : 8'h00;
    end
  end

  // RX scoreboard: every accepted byte must match the next expected one
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected got=0x%0h required=none at %0t", rx_data, $time);
        end else begin
          chk("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic cs_begin();
    spi_clk = cpol;
    clk_wait(4);
    spi_cs_n = 1'b0;
    clk_wait(10);
  endtask

  task automatic cs_end();
    clk_wait(HALF);
    spi_cs_n = 1'b1;
    clk_wait(10);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      idx = msb_first ? 7 - i : i;
      if (!cpha) begin
        spi_mosi = mo[idx];
        clk_wait(HALF);
        spi_clk = ~cpol;
        mi[idx] = spi_miso;
        clk_wait(HALF);
        spi_clk = cpol;
      end else begin
        clk_wait(HALF);
        spi_clk = ~cpol;
        spi_mosi = mo[idx];
        clk_wait(HALF);
        spi_clk = cpol;
        mi[idx] = spi_miso;
      end
    end
  endtask

  task automatic set_mode(input logic p, input logic h, input logic m);
    cpol = p;
    cpha = h;
    msb_first = m;
    spi_clk = p;
    clk_wait(3);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    clk_wait(1);
    clr_status = 1'b0;
    clk_wait(1);
  endtask

  initial begin
    logic [7:0] rd0, rd1;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h5A, 8'h81, 8'h5A};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h0F, 8'hE1, 8'h0F, 8'hE1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h7E, 8'h18, 8'h7E, 8'h18};

    // reset values while held in reset
    clk_wait(3);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso", spi_miso, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_underrun", underrun, 0);
    nrst = 1'b1;
    clk_wait(5);

    // two-byte frame, mode 0, msb first
    set_mode(1'b0, 1'b0, 1'b1);
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hFF);
    clk_wait(2);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    cs_begin();
    chk("busy_in_frame", busy, 1);
    xfer(8'h00, 8, rd0);
    xfer(8'h01, 8, rd1);
    cs_end();
    chk("m0_miso_b0", rd0, 8'hA5);
    chk("m0_miso_b1", rd1, 8'h3C);
    chk("m0_no_underrun", underrun, 0);
    chk("busy_after_frame", busy, 0);
    chk("miso_idle", spi_miso, 0);

    // single-byte frames across modes and bit orders
    for (int v = 0; v < 7; v++) begin
      set_mode(vecs[v].cpol, vecs[v].cpha, vecs[v].msb);
      tx_q.delete();
      tx_q.push_back(vecs[v].tx);
      tx_q.push_back(8'hFF);
      clk_wait(2);
      exp_q.push_back(vecs[v].exp_rx);
      cs_begin();
      xfer(vecs[v].mosi, 8, rd0);
      cs_end();
      chk($sformatf("vec%0d_miso", v), rd0, vecs[v].exp_miso);
    end

    // overrun: consumer stalled across two bytes
    set_mode(1'b0, 1'b0, 1'b1);
    pulse_clr();
    tx_q.delete();
    rx_ready = 1'b0;
    cs_begin();
    xfer(8'h11, 8, rd0);
    xfer(8'h22, 8, rd1);
    cs_end();
    chk("ovr_rx_data", rx_data, 8'h11);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_flag", overrun, EXP_ERR);
    exp_q.push_back(8'h11);
    rx_ready = 1'b1;
    clk_wait(3);
    chk("ovr_drained", rx_valid, 0);
    pulse_clr();
    chk("ovr_cleared", overrun, 0);
    chk("udr_cleared", underrun, 0);

    // underrun: only one TX byte for a two-byte frame
    tx_q.delete();
    tx_q.push_back(8'h77);
    clk_wait(2);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    cs_begin();
    xfer(8'h12, 8, rd0);
    xfer(8'h34, 8, rd1);
    cs_end();
    chk("udr_b0", rd0, 8'h77);
    chk("udr_b1", rd1, 8'h00);
    chk("udr_flag", underrun, EXP_ERR);
    pulse_clr();
    chk("udr_clr", underrun, 0);

    // abort after 4 bits, then a clean frame
    tx_q.delete();
    tx_q.push_back(8'h44);
    clk_wait(2);
    cs_begin();
    xfer(8'hF0, 4, rd0);
    cs_end();
    chk("abort_rx_valid", rx_valid, 0);
    chk("abort_busy", busy, 0);
    tx_q.delete();
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hFF);
    clk_wait(2);
    exp_q.push_back(8'h96);
    cs_begin();
    xfer(8'h96, 8, rd0);
    cs_end();
    chk("abort_next_miso", rd0, 8'h3C);

    // reset mid-frame while a byte is held
    rx_ready = 1'b0;
    tx_q.delete();
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hFF);
    tx_q.push_back(8'hFF);
    clk_wait(2);
    cs_begin();
    xfer(8'h77, 8, rd0);
    cs_end();
    chk("hold_rx_valid", rx_valid, 1);
    chk("hold_rx_data", rx_data, 8'h77);
    cs_begin();
    xfer(8'h33, 3, rd0);
    chk("pre_rst_busy", busy, 1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_rx_data", rx_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_miso", spi_miso, 0);
    chk("mid_rst_tx_ready", tx_ready, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_underrun", underrun, 0);
    spi_cs_n = 1'b1;
    spi_clk = cpol;
    clk_wait(3);
    nrst = 1'b1;
    rx_ready = 1'b1;
    clk_wait(5);

    tx_q.delete();
    tx_q.push_back(8'h69);
    tx_q.push_back(8'hFF);
    clk_wait(2);
    exp_q.push_back(8'hB4);
    cs_begin();
    xfer(8'hB4, 8, rd0);
    cs_end();
    chk("post_rst_miso", rd0, 8'h69);

    clk_wait(20);
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
